jk_ff: RTL and testbench

JK_FF -- requirements
Module: jk_ff

---
 rtl/jk_ff.sv | 24 ++
 tb/tb_jk_ff.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/jk_ff.sv
// jk_ff: falling-edge JK flip-flop with asynchronous active-low reset to INIT.
module jk_ff #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic j,
  input  logic k,
  input  logic reset,
  output logic q,
  output logic qbar
);
  always_ff @(negedge clk or negedge reset)
    if (!reset) q <= INIT;
    else
      // Unknown j/k falls through to default so q goes X rather than holding.
      case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= 1'bx;
      endcase
  assign qbar = ~q;
endmodule

// File: tb/tb_jk_ff.sv
// tb_jk_ff: scoreboard bench for jk_ff covering truth table, edge selectivity, async reset, ripple chain and INIT=1.
module tb_jk_ff;
  logic clk, j, k, reset_main, reset_chain, reset_one;
  logic q, qbar, q1, qbar1;
  logic [3:0] cq, cqb;
  logic one;
  logic [3:0] sb[$];
  logic [3:0] e;
  int n_checks, n_fail;

  jk_ff dut (.clk(clk), .j(j), .k(k), .reset(reset_main), .q(q), .qbar(qbar));
  jk_ff #(.INIT(1'b1)) dut1 (.clk(clk), .j(j), .k(k), .reset(reset_one), .q(q1), .qbar(qbar1));
  jk_ff c0 (.clk(clk),   .j(one), .k(one), .reset(reset_chain), .q(cq[0]), .qbar(cqb[0]));
  jk_ff c1 (.clk(cq[0]), .j(one), .k(one), .reset(reset_chain), .q(cq[1]), .qbar(cqb[1]));
  jk_ff c2 (.clk(cq[1]), .j(one), .k(one), .reset(reset_chain), .q(cq[2]), .qbar(cqb[2]));
  jk_ff c3 (.clk(cq[2]), .j(one), .k(one), .reset(reset_chain), .q(cq[3]), .qbar(cqb[3]));

  task automatic tick;
    #5 clk = 1'b1;
    #5 clk = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    j = 1'b1; k = 1'b1;
    #1;
    n_checks++;
    if (q !== 1'b0 || qbar !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_immediate: q=%b qbar=%b, required q=0 qbar=1", q, qbar);
    end
    for (int i = 0; i < 3; i++) begin
      sb.push_back(4'd0);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (q !== e[0] || qbar !== ~e[0]) begin
        n_fail++;
        $display("FAIL reset_hold edge %0d: q=%b qbar=%b, required q=%b", i, q, qbar, e[0]);
      end
    end
    reset_main = 1'b1;
  endtask

  task automatic test_truth_table;
    logic [1:0] jk[5] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b11};
    logic       ex[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      {j, k} = jk[i];
      sb.push_back({3'b0, ex[i]});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (q !== e[0] || qbar !== ~e[0]) begin
        n_fail++;
        $display("FAIL truth_table step %0d jk=%b: q=%b qbar=%b, required q=%b", i, jk[i], q, qbar, e[0]);
      end
    end
  endtask

  task automatic test_edge_select;
    j = 1'b1; k = 1'b0;
    #5 clk = 1'b1;
    #1;
    n_checks++;
    if (q !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_rise_only: q=%b, required 0", q);
    end
    j = 1'b0; k = 1'b0;
    sb.push_back(4'd0);
    #4 clk = 1'b0;
    #1;
    e = sb.pop_front();
    n_checks++;
    if (q !== e[0]) begin
      n_fail++;
      $display("FAIL edge_fall_applies_late_jk: q=%b, required %b", q, e[0]);
    end
    j = 1'b1; k = 1'b1;
    #2;
    n_checks++;
    if (q !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_jk_change_no_edge: q=%b, required 0", q);
    end
    sb.push_back(4'd1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (q !== e[0]) begin
      n_fail++;
      $display("FAIL edge_toggle_at_fall: q=%b, required %b", q, e[0]);
    end
  endtask

  task automatic test_async_reset;
    #2 reset_main = 1'b0;
    #1;
    n_checks++;
    if (q !== 1'b0 || qbar !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_immediate: q=%b qbar=%b, required q=0 qbar=1", q, qbar);
    end
    sb.push_back(4'd0);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (q !== e[0]) begin
      n_fail++;
      $display("FAIL async_reset_hold_over_fall: q=%b, required %b", q, e[0]);
    end
    reset_main = 1'b1;
    sb.push_back(4'd1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (q !== e[0]) begin
      n_fail++;
      $display("FAIL first_fall_after_release: q=%b, required %b", q, e[0]);
    end
    sb.push_back(4'd0);
    #5 clk = 1'b1;
    #5 begin clk = 1'b0; reset_main = 1'b0; end
    #1;
    e = sb.pop_front();
    n_checks++;
    if (q !== e[0] || qbar !== ~e[0]) begin
      n_fail++;
      $display("FAIL reset_same_step_as_fall: q=%b qbar=%b, required q=%b", q, qbar, e[0]);
    end
    reset_main = 1'b1;
  endtask

  task automatic test_ripple;
    #1;
    n_checks++;
    if (cq !== 4'd0 || cqb !== 4'hf) begin
      n_fail++;
      $display("FAIL ripple_reset: q=%b qbar=%b, required q=0000 qbar=1111", cq, cqb);
    end
    reset_chain = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      sb.push_back(4'(n % 16));
      tick();
      e = sb.pop_front();
      n_checks++;
      if (cq !== e) begin
        n_fail++;
        $display("FAIL ripple_count edge %0d: q=%b, required %b", n, cq, e);
      end
    end
  endtask

  task automatic test_init1;
    j = 1'b0; k = 1'b1;
    #1;
    n_checks++;
    if (q1 !== 1'b1 || qbar1 !== 1'b0) begin
      n_fail++;
      $display("FAIL init1_reset: q=%b qbar=%b, required q=1 qbar=0", q1, qbar1);
    end
    reset_one = 1'b1;
    sb.push_back(4'd0);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (q1 !== e[0] || qbar1 !== ~e[0]) begin
      n_fail++;
      $display("FAIL init1_clear: q=%b qbar=%b, required q=%b", q1, qbar1, e[0]);
    end
  endtask

  initial begin
    clk = 1'b0; j = 1'b0; k = 1'b0; one = 1'b1;
    reset_main = 1'b0; reset_chain = 1'b0; reset_one = 1'b0;
    n_checks = 0; n_fail = 0;
    test_reset();
    test_truth_table();
    test_edge_select();
    test_async_reset();
    test_ripple();
    test_init1();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
